// File: rtl/input_port_pkg.sv
// Shared constants for the manual-input front end (input_port).
package input_port_pkg;

   localparam int INPUT_DEBOUNCE_CYCLES = 500_000;
   localparam int INPUT_NUM_KEYS        = 2;
   localparam int INPUT_SWITCH_WIDTH    = 8;

endpackage : input_port_pkg

// File: rtl/input_port_debouncer.sv
// One-bit synchronizer plus debouncer for a single board input.
// The raw pin passes two flops before it is compared with the stable value.
// The stable value is updated only after DEBOUNCE_CYCLES consecutive
// disagreeing samples. INVERT turns an active-low pin into an active-high
// level after synchronization. SYNC_RST_VAL is the idle pin level that the
// synchronizer holds during reset.
module input_port_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter bit SYNC_RST_VAL    = 1'b0,
   parameter bit INVERT          = 1'b0
) (
   input  logic clock,
   input  logic reset_s2_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_in;
   logic             w_accept;

   assign w_in     = r_sync2 ^ INVERT;
   assign w_accept = (w_in != r_stable) && (r_cnt == CNT_LAST);
   assign o_level  = r_stable;
   assign o_rise   = w_accept & w_in;

   // Two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         r_sync1 <= SYNC_RST_VAL;
         r_sync2 <= SYNC_RST_VAL;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive disagreeing samples; a glitch back to stable restarts at 0
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (w_in == r_stable) begin
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_stable <= w_in;
         r_cnt    <= '0;
      end else begin
         r_cnt    <= r_cnt + 1'b1;
      end
   end

endmodule : input_port_debouncer

// File: rtl/input_port.sv
// Manual-input front end: debounced push-buttons and slide switches with
// one-cycle press events for the CPU IN path.
// Optional feature macro INPUT_PORT_IRQ_EN adds a pending/IRQ register that
// latches presses until irq_ack.
module input_port
   import input_port_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = INPUT_DEBOUNCE_CYCLES,
   parameter int NUM_KEYS        = INPUT_NUM_KEYS
) (
   input  logic                          clock,
   input  logic                          reset_s2_n,
   input  logic                          enable,
   input  logic [NUM_KEYS-1:0]           key_n,
   input  logic [INPUT_SWITCH_WIDTH-1:0] switch,
   output logic [INPUT_SWITCH_WIDTH-1:0] switch_value,
   output logic [NUM_KEYS-1:0]           key_pressed,
   output logic [NUM_KEYS-1:0]           key_event
`ifdef INPUT_PORT_IRQ_EN
   ,
   output logic [NUM_KEYS-1:0]           pending,
   output logic                          irq,
   input  logic                          irq_ack
`endif
);

   logic [NUM_KEYS-1:0]           w_key_rise;
   logic [INPUT_SWITCH_WIDTH-1:0] w_unused_sw_rise;
   logic [NUM_KEYS-1:0]           r_key_event;

   // Keys idle high on the pin and are inverted to active-high after syncing
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      input_port_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_RST_VAL    (1'b1),
         .INVERT          (1'b1)
      ) u_deb (
         .clock      (clock),
         .reset_s2_n (reset_s2_n),
         .i_raw      (key_n[gi]),
         .o_level    (key_pressed[gi]),
         .o_rise     (w_key_rise[gi])
      );
   end

   // Switches are plain levels; their rise strobes are not used
   for (genvar gs = 0; gs < INPUT_SWITCH_WIDTH; gs++) begin : g_sw
      input_port_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_RST_VAL    (1'b0),
         .INVERT          (1'b0)
      ) u_deb (
         .clock      (clock),
         .reset_s2_n (reset_s2_n),
         .i_raw      (switch[gs]),
         .o_level    (switch_value[gs]),
         .o_rise     (w_unused_sw_rise[gs])
      );
   end

   // Press event lands on the same edge as the key_pressed rise, gated by enable
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) r_key_event <= '0;
      else             r_key_event <= w_key_rise & {NUM_KEYS{enable}};
   end

   assign key_event = r_key_event;

`ifdef INPUT_PORT_IRQ_EN
   logic [NUM_KEYS-1:0] r_pending;
   logic                r_irq;
   logic [NUM_KEYS-1:0] w_pending_nxt;

   // A new event wins over a simultaneous acknowledge for its own bit
   assign w_pending_nxt = r_key_event | (r_pending & ~{NUM_KEYS{irq_ack}});

   // Latch presses until acknowledged; irq follows next-state pending
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         r_pending <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_irq     <= |w_pending_nxt;
      end
   end

   assign pending = r_pending;
   assign irq     = r_irq;
`endif

endmodule : input_port

// File: tb/tb_input_port.sv
// Directed bench for input_port with DEBOUNCE_CYCLES = 4.
// Builds with or without INPUT_PORT_IRQ_EN.
module tb_input_port;

   logic       clock = 1'b0;
   logic       reset_s2_n;
   logic       enable;
   logic [1:0] key_n;
   logic [7:0] switch;
   logic [7:0] switch_value;
   logic [1:0] key_pressed;
   logic [1:0] key_event;
`ifdef INPUT_PORT_IRQ_EN
   logic [1:0] pending;
   logic       irq;
   logic       irq_ack;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   input_port #(.DEBOUNCE_CYCLES(4), .NUM_KEYS(2)) dut (
      .clock        (clock),
      .reset_s2_n   (reset_s2_n),
      .enable       (enable),
      .key_n        (key_n),
      .switch       (switch),
      .switch_value (switch_value),
      .key_pressed  (key_pressed),
      .key_event    (key_event)
`ifdef INPUT_PORT_IRQ_EN
      ,
      .pending      (pending),
      .irq          (irq),
      .irq_ack      (irq_ack)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge; sampling happens 1 time unit later
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ack_pulse();
`ifdef INPUT_PORT_IRQ_EN
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
`else
      tick();
`endif
   endtask

   logic [7:0] seen;
   logic [1:0] seen_pend;

   initial begin
      reset_s2_n = 1'b0;
      enable     = 1'b1;
      key_n      = 2'b00;
      switch     = 8'hFF;
`ifdef INPUT_PORT_IRQ_EN
      irq_ack    = 1'b0;
`endif
      // Reset with all inputs active
      repeat (3) tick();
      check("rst_switch_value", 32'(switch_value), 32'h00);
      check("rst_key_pressed", 32'(key_pressed), 32'h0);
      check("rst_key_event", 32'(key_event), 32'h0);
`ifdef INPUT_PORT_IRQ_EN
      check("rst_pending", 32'(pending), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
`endif
      reset_s2_n = 1'b1;
      seen = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen = seen | switch_value | {6'b0, key_pressed} | {6'b0, key_event};
      end
      check("requal_early", 32'(seen), 32'h00);
      tick();
      check("requal_key_pressed", 32'(key_pressed), 32'h3);
      check("requal_switch_value", 32'(switch_value), 32'hFF);
      check("requal_key_event", 32'(key_event), 32'h3);
      tick();
      check("requal_event_fall", 32'(key_event), 32'h0);
`ifdef INPUT_PORT_IRQ_EN
      check("requal_pending", 32'(pending), 32'h3);
      check("requal_irq", 32'(irq), 32'h1);
`endif
      ack_pulse();

      // Release both keys: no event
      key_n = 2'b11;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | {6'b0, key_event};
      end
      check("release_no_event", 32'(seen), 32'h0);
      check("release_level", 32'(key_pressed), 32'h0);

      // Clean press of key 0
      key_n = 2'b10;
      seen = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen = seen | {6'b0, key_pressed} | {6'b0, key_event};
      end
      check("press0_early", 32'(seen), 32'h0);
      tick();
      check("press0_level", 32'(key_pressed), 32'h1);
      check("press0_event", 32'(key_event), 32'h1);
      tick();
      check("press0_event_fall", 32'(key_event), 32'h0);
`ifdef INPUT_PORT_IRQ_EN
      check("press0_pending", 32'(pending), 32'h1);
      check("press0_irq", 32'(irq), 32'h1);
      ack_pulse();
      check("ack_pending", 32'(pending), 32'h0);
      check("ack_irq", 32'(irq), 32'h0);
      ack_pulse();
      check("ack_idle_pending", 32'(pending), 32'h0);
      check("ack_idle_irq", 32'(irq), 32'h0);
`endif

      // Release key 0: no event
      key_n = 2'b11;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | {6'b0, key_event};
      end
      check("release0_no_event", 32'(seen), 32'h0);
      check("release0_level", 32'(key_pressed), 32'h0);

      // Switch bounce on bit 3
      switch = 8'h00;
      repeat (10) tick();
      check("sw_settle_low", 32'(switch_value), 32'h00);
      seen = '0;
      switch = 8'h08;
      repeat (2) begin tick(); seen = seen | switch_value; end
      switch = 8'h00;
      repeat (2) begin tick(); seen = seen | switch_value; end
      switch = 8'h08;
      repeat (5) begin tick(); seen = seen | switch_value; end
      check("sw_bounce_hold", 32'(seen), 32'h00);
      tick();
      check("sw_bounce_accept", 32'(switch_value), 32'h08);

      // Key 1 pressed with enable low
      enable = 1'b0;
      key_n  = 2'b01;
      seen = '0;
      seen_pend = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | {6'b0, key_event};
`ifdef INPUT_PORT_IRQ_EN
         seen_pend = seen_pend | pending;
`endif
      end
      check("gate_level", 32'(key_pressed), 32'h2);
      check("gate_no_event", 32'(seen), 32'h0);
`ifdef INPUT_PORT_IRQ_EN
      check("gate_no_pending", 32'(seen_pend), 32'h0);
`endif
      enable = 1'b1;
      key_n  = 2'b11;
      repeat (12) tick();
      check("gate_release", 32'(key_pressed), 32'h0);

      // Key 0 then key 1 two cycles later; ack collides with key 1 event
      key_n = 2'b10;
      repeat (2) tick();
      key_n = 2'b00;
      repeat (5) tick();
      check("pair_k0_done", 32'(key_event), 32'h0);
`ifdef INPUT_PORT_IRQ_EN
      check("pair_pending0", 32'(pending), 32'h1);
      check("pair_irq0", 32'(irq), 32'h1);
`endif
      tick();
      check("pair_k1_event", 32'(key_event), 32'h2);
      check("pair_level", 32'(key_pressed), 32'h3);
      ack_pulse();
      check("pair_k1_event_fall", 32'(key_event), 32'h0);
`ifdef INPUT_PORT_IRQ_EN
      check("collide_pending", 32'(pending), 32'h2);
      check("collide_irq", 32'(irq), 32'h1);
      ack_pulse();
      check("final_pending", 32'(pending), 32'h0);
      check("final_irq", 32'(irq), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_input_port

// File: doc/input_port.md
# input_port

Front end for the board's manual inputs: synchronizes and debounces the push-buttons and slide switches and presents them to the CPU's IN path as stable values plus one-cycle press events. It is the input-side counterpart of the 7-segment display block and sits between the board pins and the CPU I/O logic. An optional pending/IRQ register latches presses until the CPU acknowledges them.

## Interface
- DEBOUNCE_CYCLES, 500_000, consecutive cycles a synchronized input must differ from its stable value before it is accepted (10 ms at 50 MHz); must be ≥ 2.
- NUM_KEYS, 2, number of push-buttons.
- clock  in  1  50 MHz system clock.
- reset_s2_n  in  1  Reset: asynchronous, active-low, synchronized release.
- enable  in  1  High: press events are generated.
- key_n  in  NUM_KEYS  Raw push-buttons, active-low, asynchronous.
- switch  in  8  Raw slide switches, asynchronous.
- switch_value  out  8  Debounced switch levels.
- key_pressed  out  NUM_KEYS  Debounced key levels, active-high.
- key_event  out  NUM_KEYS  One-cycle pulse per accepted press.
- pending  out  NUM_KEYS  Latched presses awaiting acknowledge. Present only with INPUT_PORT_IRQ_EN.
- irq  out  1  High while any pending bit is set. Present only with INPUT_PORT_IRQ_EN.
- irq_ack  in  1  One-cycle pulse that clears pending. Present only with INPUT_PORT_IRQ_EN.

## Operation
- Every key_n and switch bit passes a two-flop synchronizer.
  - key_n synchronizer flops reset to 1 (released).
  - switch synchronizer flops reset to 0.
- Keys are inverted after synchronization to give active-high levels.
- Each of the NUM_KEYS + 8 bits has its own debouncer: a stable value and a counter of width $clog2(DEBOUNCE_CYCLES).
  - Synced bit equals stable value: counter cleared to 0.
  - Synced bit differs and counter == DEBOUNCE_CYCLES-1: stable value takes the synced bit, counter cleared, rise strobe asserted if the new value is 1.
  - Synced bit differs otherwise: counter increments.
- Any glitch that returns to the stable value restarts the count from 0.
- key_event[i] is registered. It is 1 for exactly one cycle on the same edge that key_pressed[i] goes 0→1, and only if enable is high at that edge.
- Key releases produce no event. Switch changes produce no event.
- enable low:
  - key_event is forced to 0.
  - Debouncing continues, so key_pressed and switch_value remain valid.
- Reset value of every output is 0: switch_value, key_pressed, key_event, pending, irq.
- Reset mid-count clears all counters. After release, an input that is already active must be re-qualified for a full DEBOUNCE_CYCLES.

## Timing
- A raw change that meets setup before edge E0 updates its stable output at edge E(DEBOUNCE_CYCLES+1).
  - That is 2 synchronizer edges plus DEBOUNCE_CYCLES counting edges.
- key_event is asserted on the same edge as the key_pressed rise.
- Minimum spacing between two events on one key is 2·DEBOUNCE_CYCLES cycles: press, release, press.
- Counters never wrap: they clear on acceptance, or when the input matches the stable value.

## Configuration
- Macro: INPUT_PORT_IRQ_EN.
- Defined:
  - pending[i] is set by key_event[i] and cleared for all bits by irq_ack.
  - If key_event[i] and irq_ack occur in the same cycle, pending[i] ends at 1 (the set wins); other bits clear.
  - irq is registered as the OR of next-state pending, so irq rises on the edge after key_event.
  - irq_ack while nothing is pending has no effect.
- Undefined: pending, irq and irq_ack ports and their logic are absent. Only the level and event outputs exist.

## Structure
- Package def holds:
  - INPUT_DEBOUNCE_CYCLES (500_000)
  - INPUT_NUM_KEYS (2)
  - INPUT_SWITCH_WIDTH (8)
- Sub-module debouncer: one bit, parameter DEBOUNCE_CYCLES.
  - Contains the synchronizer, counter and stable flop.
  - Outputs the stable level and a rise strobe.
  - Instantiated NUM_KEYS + 8 times via generate.
- Top level holds key inversion, enable gating, key_event registers and the IRQ logic.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4.
- Reset: hold reset_s2_n low with key_n = 2'b00 and switch = 8'hFF.
  - During reset: all outputs are 0.
  - After release: key_pressed = 2'b11 and switch_value = 8'hFF appear after exactly 6 edges, with key_event = 2'b11 for one cycle.
- Clean press: drive key_n[0] low at E0.
  - key_pressed[0] and key_event[0] rise at E5; key_event[0] falls at E6.
  - Releasing the key gives no event.
- Bounce: toggle switch[3] 0→1→0→1 with 2-cycle intervals, then hold it.
  - switch_value[3] changes only 6 edges after the final transition.
  - No intermediate change is seen.
- Enable gating: press key 1 with enable = 0.
  - key_pressed[1] rises; key_event stays 0; pending stays 0.
- IRQ, with the macro defined:
  - Press key 0: pending = 2'b01 and irq = 1 one edge later.
  - Pulse irq_ack: pending = 0 and irq = 0.
  - Press key 1 in the same cycle as irq_ack, with pending = 2'b01: pending = 2'b10 and irq stays 1.
- Macro undefined: the same press stimulus elaborates without pending, irq or irq_ack, and key_event behaves identically.
